tx_buffer_ctrl: RTL and testbench
=================================

TX_BUFFER_CTRL -- requirements
Module: tx_buffer_ctrl

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, data byte width.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; fixed at 4 with 2-bit address.
REQ-003 tClk  in  1  sole clock; all state changes on its rising edge.
REQ-004 tRst  in  1  reset, asynchronous, active-high.
REQ-005 txEn  in  1  when high, new fetches from the buffer are permitted.
REQ-006 hWrReq  in  1  host write request; held high until hWrAck.
REQ-007 hData  in  BITWIDTH  host byte to enqueue.
REQ-008 hWrAck  out  1  one-cycle pulse when the byte is written to the buffer.
REQ-009 hFull  out  1  high when count==4.
REQ-010 tWR  out  1  buffer write strobe.
REQ-011 tRD  out  1  buffer read strobe.
REQ-012 tpaddr  out  2  buffer entry address.
REQ-013 tdataIn  out  BITWIDTH  write data to the buffer.
REQ-014 bRdData  in  BITWIDTH  buffer read data, valid the cycle after tRD.
REQ-015 sLoad  out  1  one-cycle pulse loading sData into the serializer.
REQ-016 sData  out  BITWIDTH  registered byte for the serializer.
REQ-017 sDone  in  1  one-cycle pulse from the serializer at stop-bit end.
REQ-018 txEmpty  out  1  high when count==0 and FSM is IDLE.
REQ-019 count  out  3  bytes held in the buffer, 0..4.

Function
REQ-020 Write pointer wrPtr and read pointer rdPtr SHALL be 2-bit and wrap 3->0.
REQ-021 A write SHALL be accepted when hWrReq=1 and count<4: tWR=1, tRD=0, tpaddr=wrPtr, tdataIn=hData, hWrAck=1, wrPtr+1 in the same cycle.
REQ-022 With hWrReq=1 and count==4, no write SHALL occur and hWrAck SHALL stay 0.
REQ-023 tWR and tRD SHALL never be high in the same cycle.
REQ-024 The FSM SHALL have states IDLE, FETCH, CAPTURE, LOAD, WAIT.
REQ-025 IDLE->FETCH when txEn=1 and count>0; otherwise stay IDLE.
REQ-026 FETCH: if a write is accepted this cycle, stall in FETCH with tRD=0; else tRD=1, tpaddr=rdPtr, rdPtr+1, count-1, go to CAPTURE.
REQ-027 CAPTURE: sData <= bRdData, go to LOAD.
REQ-028 LOAD: sLoad=1 for one cycle, go to WAIT.
REQ-029 WAIT: on sDone go to FETCH if txEn=1 and count>0, else IDLE.
REQ-030 Latency IDLE-with-data to sLoad SHALL be 3 cycles absent write stalls.
REQ-031 Write accept and read fetch in one cycle is impossible; count SHALL change by exactly +1, -1 or 0 per cycle.
REQ-032 txEn falling SHALL NOT abort a byte in CAPTURE/LOAD/WAIT; it only blocks the next fetch.
REQ-033 sDone outside WAIT SHALL be ignored.
REQ-034 When neither write nor fetch is active, tWR=tRD=0 and tpaddr=rdPtr.

Reset
REQ-035 tRst=1 SHALL immediately force state IDLE, wrPtr=rdPtr=0, count=0, sData=0, and all strobes (tWR, tRD, hWrAck, sLoad) 0.
REQ-036 Reset mid-transfer SHALL discard buffered bytes; txEmpty=1, hFull=0 during and after reset.

Structure
REQ-037 Shared package SHALL hold BITWIDTH default, DEPTH, pointer width, and FSM state encoding constants.
REQ-038 Pointer/count logic SHALL be a sub-module tx_ptr_ctrl; FSM and strobe muxing stay in tx_buffer_ctrl.

Verification
REQ-039 Write 0xA5 with txEn=0 -> hWrAck pulse, tpaddr=0, count=1, no tRD; raise txEn -> tRD after 1 cycle, sLoad with sData=0xA5 3 cycles after txEn rises.
REQ-040 Write 5 bytes 0x01..0x05, txEn=0 -> 4 acks at tpaddr 0,1,2,3, hFull=1, fifth held unacked until a fetch frees space.
REQ-041 Stream 6 bytes with sDone 10 cycles after each sLoad -> sData sequence in order, tpaddr wraps 3->0, txEmpty=1 at end.
REQ-042 hWrReq asserted in the FETCH cycle -> write granted, tRD deferred one cycle, never both strobes high.
REQ-043 Assert tRst during WAIT with count=2 -> all outputs reset immediately, count=0, stale sDone after release ignored.

Source files
------------

// File: rtl/tx_buffer_ctrl_pkg.sv
// Shared constants and FSM encoding for the transmit buffer controller.
package tx_buffer_ctrl_pkg;

    localparam int BITWIDTH_DEF = 8;
    localparam int BUF_DEPTH    = 4;
    localparam int PTR_W        = 2;
    localparam int CNT_W        = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_LOAD    = 3'd3,
        S_WAIT    = 3'd4
    } tx_state_t;

endpackage

// File: rtl/tx_ptr_ctrl.sv
// Write/read pointers and occupancy count for the 4-entry transmit buffer.
module tx_ptr_ctrl
    import tx_buffer_ctrl_pkg::*;
(
    input  logic             tClk,
    input  logic             tRst,
    input  logic             wrEn,
    input  logic             rdEn,
    output logic [PTR_W-1:0] wrPtr,
    output logic [PTR_W-1:0] rdPtr,
    output logic [CNT_W-1:0] count
);

    // Pointers wrap naturally at the 2-bit boundary; wrEn and rdEn are exclusive upstream.
    always_ff @(posedge tClk or posedge tRst) begin
        if (tRst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn)
                wrPtr <= wrPtr + 1'b1;
            if (rdEn)
                rdPtr <= rdPtr + 1'b1;
            case ({wrEn, rdEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_buffer_ctrl.sv
// Host-to-serializer transmit buffer sequencer: arbitrates buffer writes and
// fetches, then hands each byte to the serializer and waits for its completion.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing in flight; start when txEn=1 and buffer not empty
// FETCH   | issue buffer read unless a host write owns the port
// CAPTURE | buffer read data valid; latch into sData
// LOAD    | sLoad pulse to the serializer
// WAIT    | serializer busy; sDone selects next fetch or idle
module tx_buffer_ctrl
    import tx_buffer_ctrl_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF,
    parameter int DEPTH    = BUF_DEPTH
) (
    input  logic                tClk,
    input  logic                tRst,
    input  logic                txEn,
    input  logic                hWrReq,
    input  logic [BITWIDTH-1:0] hData,
    output logic                hWrAck,
    output logic                hFull,
    output logic                tWR,
    output logic                tRD,
    output logic [PTR_W-1:0]    tpaddr,
    output logic [BITWIDTH-1:0] tdataIn,
    input  logic [BITWIDTH-1:0] bRdData,
    output logic                sLoad,
    output logic [BITWIDTH-1:0] sData,
    input  logic                sDone,
    output logic                txEmpty,
    output logic [CNT_W-1:0]    count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    tx_state_t        state;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             wrAcc;
    logic             rdFetch;
    logic             hasData;

    // Host writes win the single buffer port; a pending fetch simply stalls.
    assign wrAcc   = hWrReq && (count != FULL_CNT) && !tRst;
    assign rdFetch = (state == S_FETCH) && !wrAcc && !tRst;
    assign hasData = (count != '0);

    tx_ptr_ctrl u_ptr (
        .tClk  (tClk),
        .tRst  (tRst),
        .wrEn  (wrAcc),
        .rdEn  (rdFetch),
        .wrPtr (wrPtr),
        .rdPtr (rdPtr),
        .count (count)
    );

    assign tWR     = wrAcc;
    assign tRD     = rdFetch;
    assign hWrAck  = wrAcc;
    assign tpaddr  = wrAcc ? wrPtr : rdPtr;
    assign tdataIn = hData;
    assign hFull   = (count == FULL_CNT);
    assign txEmpty = !hasData && (state == S_IDLE);

    always_ff @(posedge tClk or posedge tRst) begin
        if (tRst) begin
            state <= S_IDLE;
            sLoad <= 1'b0;
            sData <= '0;
        end else begin
            sLoad <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (txEn && hasData)
                        state <= S_FETCH;
                end
                S_FETCH: begin
                    if (rdFetch)
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    sData <= bRdData;
                    sLoad <= 1'b1;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // txEn only gates the next fetch; the current byte always completes.
                    if (sDone)
                        state <= (txEn && hasData) ? S_FETCH : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_buffer_ctrl.sv
// Randomized and directed checks of tx_buffer_ctrl against a queue-based transfer model.
module tb_tx_buffer_ctrl;

    logic       tClk = 1'b0;
    logic       tRst;
    logic       txEn;
    logic       hWrReq;
    logic [7:0] hData;
    logic       hWrAck;
    logic       hFull;
    logic       tWR;
    logic       tRD;
    logic [1:0] tpaddr;
    logic [7:0] tdataIn;
    logic [7:0] bRdData = 8'h00;
    logic       sLoad;
    logic [7:0] sData;
    logic       sDone;
    logic       txEmpty;
    logic [2:0] count;

    logic [7:0] mem [4];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: buffer contents as a queue, plus progress of the byte in flight
    logic [7:0] q[$];
    int         wp, rp;
    bit         fpend;          // engine wants to read the next byte
    int         stage;          // 0 none, 1 read data arriving, 2 load pulse, 3 serializer busy
    logic [7:0] inflight, msdata;
    bit         e_wr, e_rd;

    int         ser_mode;       // 0 random sDone, 1 sDone 10 cycles after sLoad, 2 driven by stimulus
    int         ser_cnt;
    bit         ld_seen, last_ack;
    logic [7:0] loaded[$];
    logic [7:0] to_send[$];

    always #5 tClk = ~tClk;

    always @(posedge tClk) begin
        if (tWR) mem[tpaddr] <= tdataIn;
        if (tRD) bRdData <= mem[tpaddr];
    end

    tx_buffer_ctrl #(.BITWIDTH(8), .DEPTH(4)) dut (
        .tClk    (tClk),
        .tRst    (tRst),
        .txEn    (txEn),
        .hWrReq  (hWrReq),
        .hData   (hData),
        .hWrAck  (hWrAck),
        .hFull   (hFull),
        .tWR     (tWR),
        .tRD     (tRD),
        .tpaddr  (tpaddr),
        .tdataIn (tdataIn),
        .bRdData (bRdData),
        .sLoad   (sLoad),
        .sData   (sData),
        .sDone   (sDone),
        .txEmpty (txEmpty),
        .count   (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        q.delete();
        wp = 0; rp = 0; fpend = 0; stage = 0;
        inflight = 8'h00; msdata = 8'h00;
    endtask

    task automatic compare();
        int n;
        n    = q.size();
        e_wr = !tRst && hWrReq && (n < 4);
        e_rd = !tRst && fpend && !e_wr;
        chk("tWR",    32'(tWR),    32'(e_wr));
        chk("tRD",    32'(tRD),    32'(e_rd));
        chk("hWrAck", 32'(hWrAck), 32'(e_wr));
        chk("tpaddr", 32'(tpaddr), e_wr ? 32'(wp) : 32'(rp));
        if (e_wr) chk("tdataIn", 32'(tdataIn), 32'(hData));
        chk("count",   32'(count),   32'(n));
        chk("hFull",   32'(hFull),   32'(n == 4));
        chk("txEmpty", 32'(txEmpty), 32'(n == 0 && stage == 0 && !fpend));
        chk("sLoad",   32'(sLoad),   32'(stage == 2));
        chk("sData",   32'(sData),   32'(msdata));
        if (sLoad === 1'b1) loaded.push_back(sData);
        ld_seen  = (sLoad === 1'b1);
        last_ack = (hWrAck === 1'b1);
    endtask

    task automatic commit();
        int n0;
        bit was_idle;
        if (tRst) begin
            reset_model();
            return;
        end
        n0       = q.size();
        was_idle = (stage == 0) && !fpend;
        if (e_wr) begin
            q.push_back(hData);
            wp = (wp + 1) % 4;
        end
        if (e_rd) begin
            if (q.size() > 0) inflight = q.pop_front();
            rp    = (rp + 1) % 4;
            fpend = 0;
            stage = 1;
        end else if (stage == 1) begin
            msdata = inflight;
            stage  = 2;
        end else if (stage == 2) begin
            stage = 3;
        end else if (stage == 3 && sDone) begin
            stage = 0;
            fpend = txEn && (n0 > 0);
        end
        if (was_idle && txEn && n0 > 0) fpend = 1;
    endtask

    task automatic serializer();
        if (ser_mode == 0) begin
            sDone = ($urandom_range(0, 3) == 0);
        end else if (ser_mode == 1) begin
            if (ld_seen) ser_cnt = 10;
            sDone = 1'b0;
            if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) sDone = 1'b1;
            end
        end
    endtask

    // one clock cycle: compare at the falling edge, advance the model just after the rising edge
    task automatic tick();
        @(negedge tClk);
        compare();
        @(posedge tClk);
        #1;
        commit();
        serializer();
    endtask

    task automatic reset_pulse();
        tRst = 1'b1;
        reset_model();
        hWrReq = 1'b0; txEn = 1'b0; sDone = 1'b0; ser_cnt = 0;
        tick();
        tick();
        tRst = 1'b0;
    endtask

    task automatic host_send(input int lim);
        int   k;
        logic a;
        k = 0;
        while (to_send.size() > 0 && k < lim) begin
            hWrReq = 1'b1;
            hData  = to_send[0];
            #1;
            a = hWrAck;
            tick();
            if (a === 1'b1) void'(to_send.pop_front());
            k++;
        end
        hWrReq = 1'b0;
        chk("host_send_done", 32'(to_send.size()), 32'd0);
    endtask

    task automatic wait_empty(input int lim);
        int k;
        k = 0;
        while (txEmpty !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        chk("drain_to_empty", 32'(txEmpty), 32'd1);
    endtask

    initial begin
        int   k;
        bit   got;
        logic [1:0] tp;

        tRst = 1'b1; txEn = 1'b0; hWrReq = 1'b0; hData = 8'h00; sDone = 1'b0;
        ser_mode = 2; ser_cnt = 0;
        reset_model();
        repeat (3) tick();
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_txEmpty", 32'(txEmpty), 32'd1);
        chk("rst_hFull",   32'(hFull),   32'd0);
        chk("rst_sData",   32'(sData),   32'd0);
        tRst = 1'b0;
        tick();

        // single byte with transmit disabled, then enable
        hWrReq = 1'b1; hData = 8'hA5;
        #1;
        chk("a5_ack",  32'(hWrAck), 32'd1);
        chk("a5_addr", 32'(tpaddr), 32'd0);
        tick();
        hWrReq = 1'b0;
        #1;
        chk("a5_count", 32'(count), 32'd1);
        tick();
        tick();
        txEn = 1'b1;
        #1;
        chk("a5_no_rd_yet", 32'(tRD), 32'd0);
        tick();
        #1;
        chk("a5_rd_after_1", 32'(tRD), 32'd1);
        tick();
        tick();
        #1;
        chk("a5_sload_at_3", 32'(sLoad), 32'd1);
        chk("a5_sdata",      32'(sData), 32'hA5);
        tick();
        sDone = 1'b1;
        tick();
        sDone = 1'b0;
        #1;
        chk("a5_empty", 32'(txEmpty), 32'd1);

        // fill to full; fifth byte waits for a fetch
        reset_pulse();
        ser_mode = 1;
        for (int i = 0; i < 4; i++) begin
            hWrReq = 1'b1; hData = 8'(i + 1);
            #1;
            chk("fill_ack",  32'(hWrAck), 32'd1);
            chk("fill_addr", 32'(tpaddr), 32'(i));
            tick();
        end
        hData = 8'h05;
        #1;
        chk("full_flag",  32'(hFull),  32'd1);
        chk("full_noack", 32'(hWrAck), 32'd0);
        repeat (3) tick();
        txEn = 1'b1;
        k = 0; got = 0; tp = 2'd3;
        while (!got && k < 10) begin
            #1;
            if (hWrAck === 1'b1) begin
                got = 1;
                tp  = tpaddr;
            end
            tick();
            k++;
        end
        hWrReq = 1'b0;
        chk("fifth_ack",  32'(got), 32'd1);
        chk("fifth_addr", 32'(tp),  32'd0);
        wait_empty(200);

        // six-byte stream, fixed serializer time
        reset_pulse();
        ser_mode = 1;
        txEn = 1'b1;
        loaded.delete();
        to_send = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        host_send(100);
        wait_empty(300);
        chk("stream_len", 32'(loaded.size()), 32'd6);
        for (int i = 0; i < loaded.size(); i++)
            chk("stream_byte", 32'(loaded[i]), 32'(8'h10 + i));

        // host write collides with a fetch
        reset_pulse();
        ser_mode = 1;
        hWrReq = 1'b1; hData = 8'h33;
        tick();
        hWrReq = 1'b0; txEn = 1'b1;
        tick();
        hWrReq = 1'b1; hData = 8'h44;
        #1;
        chk("coll_wr",  32'(tWR),    32'd1);
        chk("coll_rd",  32'(tRD),    32'd0);
        chk("coll_ack", 32'(hWrAck), 32'd1);
        tick();
        hWrReq = 1'b0;
        #1;
        chk("coll_rd_deferred", 32'(tRD), 32'd1);
        chk("coll_wr_off",      32'(tWR), 32'd0);
        tick();
        wait_empty(100);

        // reset while the serializer is busy with two bytes still buffered
        reset_pulse();
        ser_mode = 2;
        to_send = '{8'hC1, 8'hC2, 8'hC3};
        host_send(20);
        txEn = 1'b1;
        k = 0;
        while (sLoad !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk("mid_sload_seen", 32'(sLoad), 32'd1);
        tick();
        #1;
        chk("mid_count2", 32'(count), 32'd2);
        #1;
        tRst = 1'b1;
        reset_model();
        #1;
        chk("mid_rst_count",   32'(count),   32'd0);
        chk("mid_rst_empty",   32'(txEmpty), 32'd1);
        chk("mid_rst_full",    32'(hFull),   32'd0);
        chk("mid_rst_sdata",   32'(sData),   32'd0);
        chk("mid_rst_strobes", 32'({tWR, tRD, hWrAck, sLoad}), 32'd0);
        tick();
        tick();
        tRst = 1'b0;
        sDone = 1'b1;
        tick();
        sDone = 1'b0;
        tick();
        tick();
        chk("stale_done_empty", 32'(txEmpty), 32'd1);
        chk("stale_done_sload", 32'(sLoad),   32'd0);

        // randomized traffic
        reset_pulse();
        ser_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hWrReq && last_ack) begin
                if ($urandom_range(0, 1) == 1) hData = 8'($urandom);
                else hWrReq = 1'b0;
            end else if (!hWrReq && $urandom_range(0, 2) == 0) begin
                hWrReq = 1'b1;
                hData  = 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) txEn = ~txEn;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
